// File: rtl/noc_pkg.sv
// Shared definitions for NoC traffic sources: flit field layout, flit types
// and the generator FSM state encoding.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam int TYPE_LSB = 30;
    localparam int DSTX_LSB = 28;
    localparam int DSTY_LSB = 26;
    localparam int SRCX_LSB = 24;
    localparam int SRCY_LSB = 22;
    localparam int LEN_LSB  = 16;
    localparam int SEQ_LSB  = 0;
    localparam int BSEQ_LSB = 16;
    localparam int IDX_LSB  = 0;

    typedef logic [31:0] flit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_WAIT,
        S_DONE
    } tg_state_t;

    // Folds a 2-bit random value into 0..mesh-1 (mesh is 2..4).
    function automatic logic [1:0] fold_coord(input logic [1:0] v, input int mesh);
        logic [2:0] m;
        logic [2:0] w;
        m = 3'(mesh);
        w = {1'b0, v};
        if (w >= m) return 2'(w - m);
        return v;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting toward bit 0; steps once
// per cycle that i_advance is high.
module noc_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_advance,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb    = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= {w_fb, r_state[15:1]};
        end
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// Synthetic packet source for one router local port: head/body/tail flits,
// pseudo-random destinations, inter-packet gap and a packet quota.
//
// state  | meaning
// IDLE   | not generating; en seen here launches via a zero-length WAIT
// HEAD   | head (or single) flit presented, waiting for ack
// BODY   | body/tail flits presented, index 1..PKT_LEN-1
// WAIT   | inter-packet gap; decides DONE / IDLE / HEAD when it expires
// DONE   | quota reached, terminal until reset
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int          SRC_X     = 0,
    parameter int          SRC_Y     = 0,
    parameter int          MESH_X    = 3,
    parameter int          MESH_Y    = 3,
    parameter int          PKT_LEN   = 4,
    parameter int          GAP       = 8,
    parameter int          NUM_PKTS  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] flit_out,
    output logic        flit_req,
    input  logic        flit_ack,
    output logic [15:0] pkt_sent,
    output logic        busy,
    output logic        done
);

    tg_state_t   r_state;
    tg_state_t   w_state_nxt;
    logic [15:0] r_seq;
    logic [5:0]  r_idx;
    logic [7:0]  r_gap;
    logic [15:0] r_pkt_sent;
    logic        r_done;

    logic [15:0] w_lfsr;
    logic        w_unused;
    logic [1:0]  w_dst_x_raw;
    logic [1:0]  w_dst_x;
    logic [1:0]  w_dst_y;
    logic        w_hit;
    logic        w_xfer;
    logic        w_head_xfer;
    logic        w_last;
    logic        w_tail_xfer;
    logic [15:0] w_sent_inc;
    flit_t       w_head;
    flit_t       w_body;

    noc_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_head_xfer),
        .o_state   (w_lfsr)
    );

    // Only the low nibble feeds destination selection.
    assign w_unused = ^w_lfsr[15:4];

    assign w_dst_x_raw = fold_coord(w_lfsr[1:0], MESH_X);
    assign w_dst_y     = fold_coord(w_lfsr[3:2], MESH_Y);
    assign w_hit       = (w_dst_x_raw == 2'(SRC_X)) && (w_dst_y == 2'(SRC_Y));
    assign w_dst_x     = !w_hit ? w_dst_x_raw :
                         ((32'(w_dst_x_raw) + 1 == MESH_X) ? 2'd0 : w_dst_x_raw + 2'd1);

    assign w_xfer      = flit_req && flit_ack;
    assign w_head_xfer = w_xfer && (r_state == S_HEAD);
    assign w_last      = (r_idx == 6'(PKT_LEN - 1));
    assign w_tail_xfer = w_xfer && (((r_state == S_HEAD) && (PKT_LEN == 1)) ||
                                    ((r_state == S_BODY) && w_last));
    assign w_sent_inc  = (r_pkt_sent == 16'hFFFF) ? 16'hFFFF : r_pkt_sent + 16'd1;

    always_comb begin
        w_head = '0;
        w_head[TYPE_LSB +: 2]  = (PKT_LEN == 1) ? FLIT_SINGLE : FLIT_HEAD;
        w_head[DSTX_LSB +: 2]  = w_dst_x;
        w_head[DSTY_LSB +: 2]  = w_dst_y;
        w_head[SRCX_LSB +: 2]  = 2'(SRC_X);
        w_head[SRCY_LSB +: 2]  = 2'(SRC_Y);
        w_head[LEN_LSB +: 6]   = 6'(PKT_LEN);
        w_head[SEQ_LSB +: 16]  = r_seq;
        w_body = '0;
        w_body[TYPE_LSB +: 2]  = w_last ? FLIT_TAIL : FLIT_BODY;
        w_body[BSEQ_LSB +: 14] = r_seq[13:0];
        w_body[IDX_LSB +: 16]  = {10'd0, r_idx};
    end

    always_comb begin
        w_state_nxt = r_state;
        flit_req    = 1'b0;
        flit_out    = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && !r_done) w_state_nxt = S_WAIT;
            end
            S_HEAD: begin
                flit_req = 1'b1;
                busy     = 1'b1;
                flit_out = w_head;
                if (w_xfer) w_state_nxt = (PKT_LEN == 1) ? S_WAIT : S_BODY;
            end
            S_BODY: begin
                flit_req = 1'b1;
                busy     = 1'b1;
                flit_out = w_body;
                if (w_xfer && w_last) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_gap == 8'd0) begin
                    if (r_done)   w_state_nxt = S_DONE;
                    else if (!en) w_state_nxt = S_IDLE;
                    else          w_state_nxt = S_HEAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_seq      <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            r_pkt_sent <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_head_xfer) begin
                r_idx <= 6'd1;
            end else if (w_xfer) begin
                r_idx <= r_idx + 6'd1;
            end
            if (r_state == S_IDLE) begin
                r_gap <= '0;
            end else if (w_tail_xfer) begin
                r_gap <= 8'(GAP);
            end else if ((r_state == S_WAIT) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end
            if (w_tail_xfer) begin
                r_seq      <= r_seq + 16'd1;
                r_pkt_sent <= w_sent_inc;
                if ((NUM_PKTS != 0) && (w_sent_inc == 16'(NUM_PKTS))) r_done <= 1'b1;
            end
        end
    end

    assign pkt_sent = r_pkt_sent;
    assign done     = r_done;

endmodule

// File: doc/noc_traffic_gen.md
# noc_traffic_gen

Per-node packet injector for the 3x3 router mesh. It drives a router's local input port with synthetic packets: a head flit carrying the routing fields, then body flits and a tail flit. Destinations are pseudo-random. One instance sits directly upstream of each router's local port in the mesh top. It replaces the ad-hoc test_in/test_req driving with a self-contained, countable traffic source.

## Interface
- SRC_X, 0, this node's X coordinate (0..MESH_X-1)
- SRC_Y, 0, this node's Y coordinate (0..MESH_Y-1)
- MESH_X, 3, mesh columns, legal 2..4
- MESH_Y, 3, mesh rows, legal 2..4
- PKT_LEN, 4, flits per packet including head, legal 1..63
- GAP, 8, idle cycles between packets, legal 0..255
- NUM_PKTS, 16, packets to send before done; 0 means unlimited
- LFSR_SEED, 16'hACE1, LFSR reset value, must be non-zero

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-low; the block resets on any rising edge with rst==0
- en  in  1  enable for packet generation
- flit_out  out  32  flit to the router local input port
- flit_req  out  1  flit_out is valid
- flit_ack  in  1  router accepts the flit; a transfer happens on an edge where flit_req && flit_ack
- pkt_sent  out  16  count of packets whose tail has transferred; saturates at 16'hFFFF
- busy  out  1  high from head presentation through tail transfer
- done  out  1  sticky; high once NUM_PKTS packets are sent (never high when NUM_PKTS==0)

## Operation
- Flit format:
  - [31:30] type: 01 head, 00 body, 10 tail, 11 single (head+tail)
  - Head: [29:28] dst_x, [27:26] dst_y, [25:24] SRC_X, [23:22] SRC_Y, [21:16] PKT_LEN, [15:0] pkt_seq
  - Body/tail: [29:16] pkt_seq[13:0], [15:0] flit index (head=0, first body=1, ...)
- pkt_seq starts at 0 and increments by 1 per tail transfer, wrapping at 16 bits.
- Destination generation:
  - The 16-bit Fibonacci LFSR uses taps 16,14,13,11 and advances exactly once per head transfer.
  - dst_x = lfsr[1:0], minus MESH_X if lfsr[1:0] ≥ MESH_X. dst_y is formed the same way from lfsr[3:2] with MESH_Y.
  - If (dst_x,dst_y)==(SRC_X,SRC_Y), dst_x becomes (dst_x+1) wrapped mod MESH_X.
- FSM states: IDLE, HEAD, BODY, WAIT, DONE.
  - IDLE: flit_req=0. If en and not done, go to HEAD next cycle.
  - HEAD: present the head flit (type 11 if PKT_LEN==1).
    - On transfer with PKT_LEN==1: packet complete; go to WAIT.
    - On transfer otherwise: go to BODY.
  - BODY: present flit indices 1..PKT_LEN-1; the last one is type 10. Go to WAIT on tail transfer.
  - WAIT: count GAP cycles (0 means skip). Then:
    - pkt_sent==NUM_PKTS (NUM_PKTS≠0): go to DONE.
    - en==0: go to IDLE.
    - else: go to HEAD.
  - DONE: terminal until reset; flit_req=0, done=1.
- Handshake: while flit_req=1 and flit_ack=0, flit_out holds stable. flit_req never drops before the transfer.
- en deasserted mid-packet: the current packet completes. en is sampled only in IDLE and WAIT.

## Timing
- Reset values: flit_out=0, flit_req=0, pkt_sent=0, busy=0, done=0, LFSR=LFSR_SEED, pkt_seq=0, state IDLE.
- Injection latency: en sampled high in IDLE at edge N → flit_req=1 with the head after edge N+1.
- With flit_ack held high, one flit transfers per cycle.
- With flit_ack=1 constant and GAP=G, consecutive heads are PKT_LEN+G+1 cycles apart (the WAIT→HEAD transition costs 1 cycle).
- pkt_sent and done update on the edge that transfers the tail.
- Reset mid-packet: all outputs return to reset values on that edge, and the partial packet is abandoned.
- flit_ack while flit_req=0 is ignored.

## Structure
- Shared package noc_pkg holds:
  - flit type localparams (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE)
  - field bit-position constants
  - typedef flit_t (logic [31:0])
  - the FSM state enum tg_state_t
- Sub-module noc_lfsr16 (seed parameter, advance input, 16-bit state output) is natural and reusable by other sources.
- Everything else stays in one module.

## Test plan
- Default parameters with SRC=(0,0) and flit_ack=1: heads arrive every 13 cycles, types are 01,00,00,10, and after the 16th tail pkt_sent=16 and done=1.
- Backpressure with flit_ack toggling 1010…: flit_out is held stable across each non-ack cycle. No flit is lost or duplicated; indices run 0,1,2,3 per packet.
- PKT_LEN=1, GAP=0: every flit has type 11 and its length field is 1. Heads are 2 cycles apart.
- Destination check with SRC=(1,1) over 1000 packets (NUM_PKTS=0): dst is never (1,1), dst_x,dst_y < 3 always, and the first dst matches a reference model seeded with 16'hACE1.
- en dropped during the second body flit: the tail is still sent, then flit_req stays 0 with the FSM in IDLE. en re-raised → head 2 cycles later with pkt_seq incremented.
- rst=0 asserted while in BODY with flit_req=1: on the next edge flit_req=0, pkt_sent=0 and pkt_seq=0. After release, the first head carries seq 0 and the seed-derived dst.
